// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared constants, state encoding and access-legality helper
//               for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // True when the request must not reach the bus: conflicting strobes,
  // unsupported size encoding, or an address not aligned to the size.
  function automatic logic access_illegal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
    logic ill;
    ill = 1'b0;
    if (rd && wr) begin
      ill = 1'b1;
    end else if (rd) begin
      case (f3)
        F3_B, F3_BU: ill = 1'b0;
        F3_H, F3_HU: ill = off[0];
        F3_W:        ill = (off != 2'b00);
        default:     ill = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        F3_B:    ill = 1'b0;
        F3_H:    ill = off[0];
        F3_W:    ill = (off != 2'b00);
        default: ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Selects the addressed byte/halfword of a 32-bit read word and
//               sign- or zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension; anything else passes the word through
  always_comb begin
    w_byte = rdata[{byte_off, 3'b000} +: 8];
    w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   result = {24'h000000, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_HU:   result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-access pipeline stage. Issues one req/ack data-bus
//               transaction per load/store, stalls upstream while it is in
//               flight, formats load data, and reports misaligned/illegal
//               accesses and ack timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              stg_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_target,
  input  logic              rd_memory,
  input  logic              wr_memory,
  input  logic [2:0]        funct3_,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic [3:0]        dbus_be,
  output logic              dbus_we,
  output logic              dbus_req,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              mem_stall,
  output logic              misalign_fault,
  output logic              bus_fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_load;
  logic               r_bus_to;
  logic [1:0]         r_off;
  logic [2:0]         r_f3;
  logic               w_req;
  logic               w_illegal;
  logic               w_timeout;
  logic               w_start;
  logic [3:0]         w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_load_fmt;

  assign w_req     = rd_memory | wr_memory;
  assign w_illegal = access_illegal(rd_memory, wr_memory, funct3_, address_target[1:0]);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_start   = (r_state == ST_IDLE) && w_req && !w_illegal;

  // Byte lanes and lane-replicated data for the incoming access
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (wr_memory) begin
      w_wdata = rs2_data;
      case (funct3_)
        F3_B: begin
          w_be    = 4'b0001 << address_target[1:0];
          w_wdata = {4{rs2_data[7:0]}};
        end
        F3_H: begin
          w_be    = address_target[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{rs2_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_formatter u_load_formatter (
    .rdata    (dbus_rdata),
    .byte_off (r_off),
    .funct3   (r_f3),
    .result   (w_load_fmt)
  );

  // Next-state logic; DONE/FAULT never look at the (stale) request inputs
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_state_next = w_illegal ? ST_FAULT : ST_BUSY;
      end
      ST_BUSY: begin
        if (dbus_ack)       w_state_next = ST_DONE;
        else if (w_timeout) w_state_next = ST_FAULT;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      ST_FAULT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Access capture, timeout counter, fault cause and load result
  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_be    <= 4'b0000;
      dbus_we    <= 1'b0;
      load_data  <= '0;
      r_cnt      <= '0;
      r_is_load  <= 1'b0;
      r_bus_to   <= 1'b0;
      r_off      <= 2'b00;
      r_f3       <= 3'b000;
    end else begin
      if ((r_state == ST_IDLE) && w_req) r_bus_to <= 1'b0;
      if (w_start) begin
        dbus_addr  <= {address_target[ADDR_W-1:2], 2'b00};
        dbus_wdata <= w_wdata;
        dbus_be    <= w_be;
        dbus_we    <= wr_memory;
        r_is_load  <= rd_memory;
        r_off      <= address_target[1:0];
        r_f3       <= funct3_;
        r_cnt      <= '0;
      end else if ((r_state == ST_BUSY) && !dbus_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_timeout) r_bus_to <= 1'b1;
      end
      if ((r_state == ST_BUSY) && dbus_ack && r_is_load) load_data <= w_load_fmt;
    end
  end

  assign dbus_req       = (r_state == ST_BUSY);
  assign load_valid     = (r_state == ST_DONE) && r_is_load;
  assign misalign_fault = (r_state == ST_FAULT) && !r_bus_to;
  assign bus_fault      = (r_state == ST_FAULT) && r_bus_to;
  // Gated with reset so the stall releases immediately on async reset
  assign mem_stall      = reset_n &&
                          (((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY));

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-access stage sitting directly downstream of the execute/memory pipeline latch. Consumes the latched effective address, rd/wr strobes, funct3 and store data. Drives a single-outstanding req/ack data-bus transaction, stalls the pipeline until it completes, and returns formatted load data. Flags misaligned or illegal accesses and bus timeouts instead of issuing them.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data bus width; fixed at 32 for RV32 byte-lane logic.
TIMEOUT, 255, maximum cycles in BUSY waiting for dbus_ack before bus_fault.

Ports:
stg_clk  in  1  pipeline clock
reset_n  in  1  asynchronous, active-low reset
address_target  in  32  effective address from the execute/memory latch
rd_memory  in  1  load request
wr_memory  in  1  store request
funct3_  in  3  access size/sign (RV32I load/store encoding)
rs2_data  in  32  store data
dbus_addr  out  32  word-aligned bus address
dbus_wdata  out  32  lane-replicated store data
dbus_be  out  4  byte enables
dbus_we  out  1  1 = write
dbus_req  out  1  request, held until ack or timeout
dbus_ack  in  1  bus completion, one-cycle pulse
dbus_rdata  in  32  read data, valid with ack
load_data  out  32  formatted load result
load_valid  out  1  one-cycle pulse with load_data
mem_stall  out  1  upstream latch must hold while high
misalign_fault  out  1  one-cycle pulse: misaligned or illegal access
bus_fault  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0; dbus_req drops immediately, even mid-transaction.
- States and transitions:
  - IDLE: a request is present when rd_memory|wr_memory.
    - Legal request: capture address, size, data and direction into registers; go to BUSY.
    - Illegal request: go to FAULT.
  - BUSY: on dbus_ack, go to DONE. On the TIMEOUT-th cycle with no ack, go to FAULT with bus_fault.
  - DONE: always returns to IDLE.
  - FAULT: always returns to IDLE.
- mem_stall (combinational) = (IDLE & request present) | BUSY.
  - mem_stall is low in DONE and FAULT, so upstream advances at the end of that cycle.
  - The inputs are still the old op in DONE/FAULT; they must never re-trigger an access.
- Illegal requests:
  - rd_memory & wr_memory both high.
  - Load funct3 011, 110 or 111.
  - Store funct3 with bit2=1, or 011.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - No bus request is issued. misalign_fault=1 for exactly the FAULT cycle.
- BUSY outputs (registered, stable for the whole of BUSY):
  - dbus_req=1.
  - dbus_addr = {addr[31:2], 2'b00}.
  - dbus_we = store.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated 4x.
  - SH: be = addr[1] ? 1100 : 0011; wdata = halfword replicated 2x.
  - SW: be = 1111.
- Load enables: dbus_be = 1111.
- On ack of a load: register the formatted dbus_rdata into load_data.
  - LB/LBU: byte selected by addr[1:0], sign-/zero-extended.
  - LH/LHU: half selected by addr[1], sign-/zero-extended.
  - LW: passthrough.
  - load_valid=1 during DONE only.
- Stores complete in DONE with load_valid=0. load_data holds its last value until the next load.
- Timeout counter: 8-bit (sized clog2(TIMEOUT+1)), cleared on entry to BUSY, increments each BUSY cycle without ack.
  - Ack on the same cycle the counter reaches TIMEOUT: ack wins, normal completion.
- dbus_ack outside BUSY is ignored.
- Minimum latency: request seen in IDLE → BUSY next edge → ack in the first BUSY cycle → DONE. That is 2 stalled cycles, then 1 release cycle.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE/BUSY/DONE/FAULT.
  - TIMEOUT default.
- One combinational sub-module, load_formatter: (rdata, addr[1:0], funct3) → 32-bit result. Reused by a future cache path.

Test Plan:
- LW addr 0x0000_1004, ack on the 1st BUSY cycle with rdata 0xDEADBEEF → dbus_addr 0x1004, be 1111, load_data 0xDEADBEEF, load_valid 1 cycle, mem_stall high exactly 2 cycles.
- LB addr 0x...1003 with rdata 0x80FF_0000 → load_data 0xFFFFFF80. Same access with LBU → 0x00000080. LH addr 0x...1002 → 0xFFFF80FF.
- SB addr 0x...2001, rs2 0x12345678 → be 0010, wdata 0x78787878, we 1, load_valid stays 0. SH addr 0x...2002 → be 1100, wdata 0x56785678.
- SW addr 0x...3002 → no dbus_req; misalign_fault pulses 1 cycle; mem_stall high only in the IDLE detect cycle. rd&wr both high → same fault.
- Load with ack withheld → bus_fault on BUSY cycle 255, req drops. Ack arriving on cycle 255 instead → normal DONE.
- reset_n low mid-BUSY → dbus_req, mem_stall low asynchronously. A late ack after reset release is ignored and produces no load_valid.
